// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, requester IDs and
// line geometry.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_I = 2'd0;
  localparam req_id_t REQ_D = 2'd1;
  localparam req_id_t REQ_W = 2'd2;

  localparam int LINE_OFS_W = 4;

  // Rotation order i -> d -> w -> i.
  function automatic req_id_t next_req(input req_id_t id);
    return (id == REQ_W) ? REQ_I : req_id_t'(id + 2'd1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory-port arbiter.
// MEM_ARB_RR_EN selects round-robin rotation instead of fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    icache_req,
  input  logic    dcache_req,
  input  logic    store_req,
  input  logic    raw_hit,
  input  logic    starve_hit,
  input  req_id_t rr_ptr,
  output req_id_t winner
);

  logic [3:0] req_vec;
  assign req_vec = {1'b0, store_req, dcache_req, icache_req};

`ifdef MEM_ARB_RR_EN
  req_id_t cand;
  logic    found;

  // starve_hit is tied low by the top in this build, so that rule is inert.
  always_comb begin
    winner = rr_ptr;
    cand   = rr_ptr;
    found  = 1'b0;
    if (raw_hit) begin
      winner = REQ_W;
    end else if (starve_hit && icache_req) begin
      winner = REQ_I;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (!found && req_vec[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
        cand = next_req(cand);
      end
    end
  end
`else
  // With no request the output is a don't-care; rr_ptr is simply a stable default.
  always_comb begin
    winner = rr_ptr;
    if (raw_hit)                        winner = REQ_W;
    else if (starve_hit && icache_req)  winner = REQ_I;
    else if (req_vec[REQ_D])            winner = REQ_D;
    else if (req_vec[REQ_W])            winner = REQ_W;
    else if (req_vec[REQ_I])            winner = REQ_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between icache fill, dcache fill and store drain.
// Build option MEM_ARB_RR_EN: round-robin instead of fixed priority + anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iRData,
  input  logic              dReq,
  input  logic [ADDR_W-1:0] dAddr,
  output logic              dAck,
  output logic [DATA_W-1:0] dRData,
  input  logic              wReq,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  output logic              wAck,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRData
);

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t     state;
  req_id_t    owner;
  req_id_t    rr_ptr;
  req_id_t    winner;
  logic [2:0] starve_cnt;
  logic       any_req;
  logic       raw_hit;
  logic       starve_hit;

  assign any_req    = iReq | dReq | wReq;
  // A dcache fill must not overtake a pending store to the same line.
  assign raw_hit    = dReq && wReq &&
                      (dAddr[ADDR_W-1:LINE_OFS_W] == wAddr[ADDR_W-1:LINE_OFS_W]);
  assign starve_hit = (starve_cnt == STARVE_LIM);

  mem_arb_pick u_pick (
    .icache_req (iReq),
    .dcache_req (dReq),
    .store_req  (wReq),
    .raw_hit    (raw_hit),
    .starve_hit (starve_hit),
    .rr_ptr     (rr_ptr),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_I;
      rr_ptr     <= REQ_I;
      starve_cnt <= '0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWData   <= '0;
      iAck       <= 1'b0;
      dAck       <= 1'b0;
      wAck       <= 1'b0;
      iRData     <= '0;
      dRData     <= '0;
    end else begin
      iAck <= 1'b0;
      dAck <= 1'b0;
      wAck <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= winner;
            memReq <= 1'b1;
            memWe  <= (winner == REQ_W);
            case (winner)
              REQ_I:   memAddr <= iAddr;
              REQ_D:   memAddr <= dAddr;
              default: memAddr <= wAddr;
            endcase
            if (winner == REQ_W) memWData <= wData;
            state <= BUSY;
`ifdef MEM_ARB_RR_EN
            rr_ptr <= next_req(winner);
`endif
          end
`ifndef MEM_ARB_RR_EN
          if (!iReq)
            starve_cnt <= '0;
          else if (any_req)
            starve_cnt <= (winner == REQ_I) ? 3'd0 :
                          (starve_hit ? starve_cnt : starve_cnt + 3'd1);
`endif
        end
        BUSY: begin
          if (memAck) begin
            memReq <= 1'b0;
            state  <= RESP;
            case (owner)
              REQ_I: begin
                iAck   <= 1'b1;
                iRData <= memRData;
              end
              REQ_D: begin
                dAck   <= 1'b1;
                dRData <= memRData;
              end
              default: wAck <= 1'b1;
            endcase
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level priority/starvation model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          iReq, dReq, wReq;
  logic [AW-1:0] iAddr, dAddr, wAddr;
  logic [DW-1:0] wData;
  logic          iAck, dAck, wAck;
  logic [DW-1:0] iRData, dRData;
  logic          memReq, memWe, memAck;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWData, memRData;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state
  int            m_starve;
  int            m_rrp;
  logic [DW-1:0] m_ilast, m_dlast;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRData(iRData),
    .dReq(dReq), .dAddr(dAddr), .dAck(dAck), .dRData(dRData),
    .wReq(wReq), .wAddr(wAddr), .wData(wData), .wAck(wAck),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memAck(memAck), .memRData(memRData)
  );

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Winner by the arbitration rules; -1 when nothing requests.
  function automatic int model_pick(input logic i, input logic d, input logic w,
                                    input logic [AW-1:0] da, input logic [AW-1:0] wa);
    logic [2:0] r;
    r = {w, d, i};
    if (d && w && (da >> 4) == (wa >> 4)) return 2;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 3; k++)
      if (r[(m_rrp + k) % 3]) return (m_rrp + k) % 3;
`else
    if (i && m_starve == SMAX) return 0;
    if (d) return 1;
    if (w) return 2;
    if (i) return 0;
`endif
    return -1;
  endfunction

  task automatic model_grant(input int win, input logic i);
`ifdef MEM_ARB_RR_EN
    m_rrp = (win + 1) % 3;
`else
    if (!i || win == 0) m_starve = 0;
    else if (m_starve < SMAX) m_starve = m_starve + 1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    m_starve = 0;
    m_rrp    = 0;
    m_ilast  = '0;
    m_dlast  = '0;
  endtask

  // Starts at a negedge in IDLE with requests driven; ends at the RESP negedge.
  task automatic run_txn(input int nwait, input logic [DW-1:0] rd,
                         output logic req, output logic we,
                         output logic [AW-1:0] addr, output logic [DW-1:0] wd,
                         output logic stable, output logic [2:0] early,
                         output logic [2:0] acks, output logic resp_req,
                         output logic [DW-1:0] ird, output logic [DW-1:0] drd);
    step();
    req    = memReq;
    we     = memWe;
    addr   = memAddr;
    wd     = memWData;
    stable = 1'b1;
    early  = {iAck, dAck, wAck};
    for (int k = 1; k < nwait; k++) begin
      step();
      if (memReq !== 1'b1 || memWe !== we || memAddr !== addr || memWData !== wd)
        stable = 1'b0;
      early |= {iAck, dAck, wAck};
    end
    memAck   = 1'b1;
    memRData = rd;
    step();
    memAck   = 1'b0;
    memRData = rand_line();
    acks     = {iAck, dAck, wAck};
    resp_req = memReq;
    ird      = iRData;
    drd      = dRData;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({memReq, memWe, iAck, dAck, wAck} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {memReq, memWe, iAck, dAck, wAck});
    end
    n_cmp++;
    if (memAddr !== '0 || memWData !== '0) begin
      n_bad++;
      $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", memAddr, memWData);
    end
    n_cmp++;
    if (iRData !== '0 || dRData !== '0) begin
      n_bad++;
      $display("FAIL reset_rdata: got i %h d %h want 0", iRData, dRData);
    end
    do_reset();
  endtask

  task automatic test_dcache_read();
    logic req, we, stable, rreq;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd, ird, drd;
    logic [2:0] early, acks;
    rd = rand_line();
    dReq = 1'b1;
    dAddr = 32'h100;
    run_txn(1, rd, req, we, addr, wd, stable, early, acks, rreq, ird, drd);
    dReq = 1'b0;
    n_cmp++;
    if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h100) begin
      n_bad++;
      $display("FAIL dread_bus: got req %b we %b addr %h want 1 0 00000100", req, we, addr);
    end
    n_cmp++;
    if (acks !== 3'b010 || early !== 3'b000) begin
      n_bad++;
      $display("FAIL dread_ack: got %b (early %b) want 010 (000)", acks, early);
    end
    n_cmp++;
    if (drd !== rd || rreq !== 1'b0) begin
      n_bad++;
      $display("FAIL dread_data: got %h req %b want %h req 0", drd, rreq, rd);
    end
    m_dlast = rd;
    step();
    n_cmp++;
    if ({iAck, dAck, wAck, memReq} !== 4'b0 || dRData !== rd) begin
      n_bad++;
      $display("FAIL dread_idle: got acks/req %b data %h want 0000 %h",
               {iAck, dAck, wAck, memReq}, dRData, rd);
    end
  endtask

  task automatic test_raw_guard();
    logic req, we, stable, rreq;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd, ird, drd;
    logic [2:0] early, acks;
    dReq = 1'b1;  dAddr = 32'h200;
    wReq = 1'b1;  wAddr = 32'h20C;  wData = rand_line();
    run_txn(2, rand_line(), req, we, addr, wd, stable, early, acks, rreq, ird, drd);
    wReq = 1'b0;
    n_cmp++;
    if (we !== 1'b1 || addr !== 32'h20C || wd !== wData || stable !== 1'b1) begin
      n_bad++;
      $display("FAIL raw_write_first: got we %b addr %h stable %b want 1 0000020c 1",
               we, addr, stable);
    end
    n_cmp++;
    if (acks !== 3'b001) begin
      n_bad++;
      $display("FAIL raw_wack: got %b want 001", acks);
    end
    step();
    rd = rand_line();
    run_txn(1, rd, req, we, addr, wd, stable, early, acks, rreq, ird, drd);
    dReq = 1'b0;
    n_cmp++;
    if (we !== 1'b0 || addr !== 32'h200 || acks !== 3'b010 || drd !== rd) begin
      n_bad++;
      $display("FAIL raw_dread_next: got we %b addr %h acks %b want 0 00000200 010", we, addr, acks);
    end
    step();
  endtask

`ifndef MEM_ARB_RR_EN
  task automatic test_starvation();
    logic req, we, stable, rreq;
    logic [AW-1:0] addr, exp_addr;
    logic [DW-1:0] wd, ird, drd;
    logic [2:0] early, acks, exp_acks;
    iReq = 1'b1;  iAddr = 32'h4000;
    dReq = 1'b1;  dAddr = 32'h1000;
    wReq = 1'b1;  wAddr = 32'h2000;  wData = rand_line();
    for (int g = 0; g < 5; g++) begin
      exp_acks = (g < 4) ? 3'b010 : 3'b100;
      exp_addr = (g < 4) ? 32'h1000 + 32'(g * 16) : 32'h4000;
      run_txn(1, rand_line(), req, we, addr, wd, stable, early, acks, rreq, ird, drd);
      n_cmp++;
      if (acks !== exp_acks || addr !== exp_addr) begin
        n_bad++;
        $display("FAIL starve_grant%0d: got acks %b addr %h want %b %h",
                 g, acks, addr, exp_acks, exp_addr);
      end
      dAddr = dAddr + 32'h10;
      if (g == 4) begin
        iReq = 1'b0;  dReq = 1'b0;  wReq = 1'b0;
      end
      step();
    end
  endtask
`endif

`ifdef MEM_ARB_RR_EN
  task automatic test_rr();
    logic req, we, stable, rreq;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, ird, drd;
    logic [2:0] early, acks;
    do_reset();
    iReq = 1'b1;  iAddr = 32'h4000;
    dReq = 1'b1;  dAddr = 32'h1000;
    wReq = 1'b1;  wAddr = 32'h8000;  wData = rand_line();
    for (int g = 0; g < 6; g++) begin
      run_txn(1, rand_line(), req, we, addr, wd, stable, early, acks, rreq, ird, drd);
      n_cmp++;
      if (acks !== (3'b100 >> (g % 3))) begin
        n_bad++;
        $display("FAIL rr_order%0d: got %b want %b", g, acks, 3'b100 >> (g % 3));
      end
      if (acks[2]) iAddr = iAddr + 32'h10;
      if (acks[1]) dAddr = dAddr + 32'h10;
      if (acks[0]) wAddr = wAddr + 32'h10;
      step();
    end
    iReq = 1'b0;  dReq = 1'b0;  wReq = 1'b0;
    step();
  endtask
`endif

  task automatic test_reset_mid_busy();
    dReq = 1'b1;
    dAddr = 32'h300;
    step();
    n_cmp++;
    if (memReq !== 1'b1) begin
      n_bad++;
      $display("FAIL rstbusy_pre: got memReq %b want 1", memReq);
    end
    rst = 1'b1;
    memAck = 1'b1;
    memRData = rand_line();
    step();
    rst = 1'b0;
    memAck = 1'b0;
    dReq = 1'b0;
    n_cmp++;
    if ({memReq, iAck, dAck, wAck} !== 4'b0 || dRData !== '0) begin
      n_bad++;
      $display("FAIL rstbusy_after: got req/acks %b dRData %h want 0000 0",
               {memReq, iAck, dAck, wAck}, dRData);
    end
    step();
    n_cmp++;
    if ({memReq, iAck, dAck, wAck} !== 4'b0) begin
      n_bad++;
      $display("FAIL rstbusy_idle: got req/acks %b want 0000", {memReq, iAck, dAck, wAck});
    end
    m_starve = 0;
    m_rrp    = 0;
    m_ilast  = '0;
    m_dlast  = '0;
  endtask

  task automatic test_random();
    logic req, we, stable, rreq;
    logic [AW-1:0] addr, exp_addr;
    logic [DW-1:0] wd, rd, ird, drd, exp_i, exp_d;
    logic [2:0] early, acks;
    int win, nw;
    for (int it = 0; it < 80; it++) begin
      win = model_pick(iReq, dReq, wReq, dAddr, wAddr);
      if (win < 0) begin
        step();
        n_cmp++;
        if (memReq !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_idle%0d: got memReq %b want 0", it, memReq);
        end
        m_starve = 0;
      end else begin
        exp_addr = (win == 0) ? iAddr : (win == 1) ? dAddr : wAddr;
        nw = $urandom_range(1, 3);
        rd = rand_line();
        run_txn(nw, rd, req, we, addr, wd, stable, early, acks, rreq, ird, drd);
        n_cmp++;
        if (req !== 1'b1 || we !== (win == 2) || addr !== exp_addr || stable !== 1'b1) begin
          n_bad++;
          $display("FAIL rand_bus%0d: got req %b we %b addr %h stable %b want 1 %b %h 1",
                   it, req, we, addr, stable, win == 2, exp_addr);
        end
        if (win == 2) begin
          n_cmp++;
          if (wd !== wData) begin
            n_bad++;
            $display("FAIL rand_wdata%0d: got %h want %h", it, wd, wData);
          end
        end
        n_cmp++;
        if (acks !== (3'b100 >> win) || early !== 3'b000 || rreq !== 1'b0) begin
          n_bad++;
          $display("FAIL rand_ack%0d: got %b early %b want %b", it, acks, early, 3'b100 >> win);
        end
        exp_i = (win == 0) ? rd : m_ilast;
        exp_d = (win == 1) ? rd : m_dlast;
        n_cmp++;
        if (ird !== exp_i || drd !== exp_d) begin
          n_bad++;
          $display("FAIL rand_rdata%0d: got i %h d %h want %h %h", it, ird, drd, exp_i, exp_d);
        end
        m_ilast = exp_i;
        m_dlast = exp_d;
        model_grant(win, iReq);
        // The served requester drops or moves on; the others keep waiting.
        if (win == 0) begin
          iReq = $urandom_range(0, 1);  iAddr = $urandom;
        end else if (win == 1) begin
          dReq = $urandom_range(0, 1);  dAddr = $urandom;
        end else begin
          wReq = $urandom_range(0, 1);  wAddr = $urandom;  wData = rand_line();
        end
        step();
        n_cmp++;
        if ({iAck, dAck, wAck, memReq} !== 4'b0) begin
          n_bad++;
          $display("FAIL rand_pulse%0d: got %b want 0000", it, {iAck, dAck, wAck, memReq});
        end
      end
      if (!iReq && $urandom_range(0, 2) == 0) begin iReq = 1'b1; iAddr = $urandom; end
      if (!dReq && $urandom_range(0, 2) == 0) begin dReq = 1'b1; dAddr = $urandom; end
      if (!wReq && $urandom_range(0, 2) == 0) begin
        wReq = 1'b1;  wAddr = $urandom;  wData = rand_line();
      end
      if (dReq && wReq && $urandom_range(0, 3) == 0)
        dAddr = {wAddr[AW-1:4], 4'($urandom)};
    end
    iReq = 1'b0;  dReq = 1'b0;  wReq = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    iReq = 1'b0;  dReq = 1'b0;  wReq = 1'b0;
    iAddr = '0;   dAddr = '0;   wAddr = '0;  wData = '0;
    memAck = 1'b0;
    memRData = '0;
    @(negedge clk);
    test_reset();
`ifdef MEM_ARB_RR_EN
    test_rr();
`endif
    test_dcache_read();
    test_raw_guard();
`ifndef MEM_ARB_RR_EN
    test_starvation();
`endif
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
